// File: rtl/bsg_manycore_pkt_launch.sv
// Remote-store launch buffer: circular packet FIFO toward the router plus an outstanding-store credit counter and fence.
// Optional simulation trace and protocol checks: define BSG_MANYCORE_PKT_LAUNCH_TRACE_EN.
module bsg_manycore_pkt_launch #(
  parameter int x_cord_width_p     = 5,
  parameter int y_cord_width_p     = 5,
  parameter int data_width_p       = 32,
  parameter int addr_width_p       = 32,
  parameter int fifo_els_p         = 4,
  parameter int max_out_credits_p  = 16,
  localparam int packet_width_lp   = 6 + addr_width_p + data_width_p + 2*y_cord_width_p + 2*x_cord_width_p,
  localparam int credit_width_lp   = $clog2(max_out_credits_p + 1)
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       v_i,
  input  logic [packet_width_lp-1:0] data_i,
  output logic                       ready_o,
  output logic                       v_o,
  output logic [packet_width_lp-1:0] data_o,
  input  logic                       yumi_i,
  input  logic                       credit_v_i,
  output logic [credit_width_lp-1:0] out_credits_o,
  output logic                       fence_o
);

  localparam int ptr_width_lp   = $clog2(fifo_els_p);
  localparam int count_width_lp = ptr_width_lp + 1;
  localparam logic [count_width_lp-1:0]  full_count_lp  = count_width_lp'(fifo_els_p);
  localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_out_credits_p);

  logic [packet_width_lp-1:0] mem [fifo_els_p];
  logic [ptr_width_lp-1:0]    head, tail;
  logic [count_width_lp-1:0]  count;
  logic [credit_width_lp-1:0] credits;
  logic                       enq, deq;

  // Handshakes: input side transfers when v_i && ready_o; output side transfers when
  // yumi_i && v_o. ready_o and v_o depend only on registered state, never on yumi_i/credit_v_i.
  assign ready_o       = (count != full_count_lp) && (credits != '0);
  assign v_o           = (count != '0);
  assign data_o        = mem[head];
  assign out_credits_o = credits;
  assign fence_o       = (count == '0) && (credits == max_credits_lp);

  assign enq = v_i & ready_o;
  assign deq = yumi_i & v_o;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      credits <= max_credits_lp;
      for (int i = 0; i < fifo_els_p; i++) mem[i] <= '0;
    end else begin
      if (enq) begin
        mem[tail] <= data_i;
        tail      <= tail + 1'b1;
      end
      if (deq) head <= head + 1'b1;

      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // An ack arriving with the counter already full is spurious and dropped.
      case ({enq, credit_v_i})
        2'b10:   credits <= credits - 1'b1;
        2'b01:   credits <= (credits == max_credits_lp) ? credits : credits + 1'b1;
        default: credits <= credits;
      endcase
    end
  end

`ifdef BSG_MANYCORE_PKT_LAUNCH_TRACE_EN
  localparam int y_lsb_lp    = x_cord_width_p;
  localparam int data_lsb_lp = 2*x_cord_width_p + 2*y_cord_width_p;
  localparam int addr_lsb_lp = data_lsb_lp + data_width_p;

  logic v_r, ready_r;

  always @(negedge clk_i) begin
    if (reset_n_i) begin
      if (enq)
        $display("[pkt_launch] enq x=%0d y=%0d addr=%h credits=%0d", data_i[x_cord_width_p-1:0],
                 data_i[y_lsb_lp +: y_cord_width_p], data_i[addr_lsb_lp +: addr_width_p], credits);
      if (deq)
        $display("[pkt_launch] deq x=%0d y=%0d addr=%h credits=%0d", data_o[x_cord_width_p-1:0],
                 data_o[y_lsb_lp +: y_cord_width_p], data_o[addr_lsb_lp +: addr_width_p], credits);
      if (credit_v_i)
        $display("[pkt_launch] credit return credits=%0d", credits);
      if (yumi_i && !v_o)
        $error("[pkt_launch] yumi_i asserted without v_o");
      if (credit_v_i && !enq && credits == max_credits_lp)
        $error("[pkt_launch] credit overflow");
      if (v_r && !ready_r && !v_i)
        $error("[pkt_launch] encoder dropped a stalled packet");
      v_r     <= v_i;
      ready_r <= ready_o;
    end else begin
      v_r     <= 1'b0;
      ready_r <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/bsg_manycore_pkt_launch.md
Name: bsg_manycore_pkt_launch

Overview:
- Sits directly downstream of the tile's remote-store packet encoder and upstream of the mesh router's local input port.
- Buffers encoded remote-store packets in a small circular FIFO and presents them to the network with valid/yumi.
- Meters outstanding stores with a credit counter, where each launched store consumes one credit and each network store acknowledgement returns one.
- Exposes a fence indication so the core can drain all remote stores.

Parameters:
- x_cord_width_p, 5, width of x coordinate fields.
- y_cord_width_p, 5, width of y coordinate fields.
- data_width_p, 32, packet data field width.
- addr_width_p, 32, packet address field width.
- fifo_els_p, 4, FIFO depth; must be a power of two and at least 2.
- max_out_credits_p, 16, maximum outstanding remote stores; at least 1.
- packet_width_lp, 6+addr_width_p+data_width_p+2*y_cord_width_p+2*x_cord_width_p, packet width; derived, not overridden.
- credit_width_lp, $clog2(max_out_credits_p+1), counter width; derived.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  reset, synchronous, active-low.
- v_i  in  1  encoder presents a remote-store packet.
- data_i  in  packet_width_lp  packet from the encoder.
- ready_o  out  1  block can accept a packet this cycle.
- v_o  out  1  packet valid toward the router.
- data_o  out  packet_width_lp  head-of-FIFO packet.
- yumi_i  in  1  router consumes data_o this cycle.
- credit_v_i  in  1  one store acknowledgement returned from the network.
- out_credits_o  out  credit_width_lp  credits currently available.
- fence_o  out  1  all stores drained: FIFO empty and out_credits_o == max_out_credits_p.

Behaviour:
- Reset: every state element is cleared when reset_n_i is low at a rising edge of clk_i.
  - Head, tail and count are 0.
  - Credits are set to max_out_credits_p.
  - Outputs after reset: v_o=0, ready_o=1, fence_o=1, data_o don't-care.
- Reset dominates every other input, including mid-operation. Buffered packets are discarded, and outstanding acks arriving after reset are counted as spurious (see credit overflow).
- ready_o = (count != fifo_els_p) && (credits != 0). It is a function of registered state only; there is no combinational path from yumi_i or credit_v_i.
- Enqueue occurs when v_i & ready_o:
  - data_i is written at the tail, tail advances modulo fifo_els_p, and count increments.
  - One credit is consumed at the same edge.
  - v_i while ready_o=0 is ignored; the encoder must hold the packet.
- Dequeue:
  - v_o = (count != 0) and data_o = mem[head].
  - When yumi_i is high, head advances modulo fifo_els_p and count decrements.
  - yumi_i while v_o=0 is illegal and ignored: no pointer movement.
- Latency: an enqueued packet is visible on v_o/data_o no earlier than the next cycle. There is no bypass.
- Simultaneous enqueue and dequeue: both pointers advance and count is unchanged. When full, no enqueue happens that cycle, even if yumi_i is high, because ready_o was already 0.
- Credit counter update:
  - Enqueue only: credit minus 1.
  - credit_v_i only: credit plus 1.
  - Both: unchanged.
- Credit overflow: credit_v_i with credits == max_out_credits_p and no enqueue. The counter saturates, holds max, and the event is ignored.
- Credit underflow cannot occur because ready_o gates enqueue at 0 credits.
- Pointer wrap: head and tail are log2(fifo_els_p) bits and wrap naturally. Full versus empty is distinguished by count, which is log2(fifo_els_p)+1 bits.
- fence_o is registered-state derived. It deasserts the cycle after an enqueue and reasserts the cycle after the last credit returns with the FIFO empty.

Optional Feature:
- BSG_MANYCORE_PKT_LAUNCH_TRACE_EN defined: simulation-only checks and trace, clocked on negedge clk_i while reset_n_i is high.
  - $display on each enqueue, dequeue and credit return, showing packet x/y coordinates, address and credits.
  - $error on yumi_i without v_o.
  - $error on credit overflow.
  - $error on v_i deasserted while ready_o was 0 and v_i was high on the previous cycle (packet dropped by the encoder).
- Undefined: no trace and no checks. Synthesized logic is identical either way.

Test Plan:
- Reset then idle: after reset_n_i low for 2 cycles, expect v_o=0, ready_o=1, fence_o=1, out_credits_o=16.
- Fill and stall: with yumi_i=0, enqueue 4 packets with data field 0x1..0x4. Expect ready_o=0 after the 4th, count 4, out_credits_o=12, and a further v_i ignored.
- Drain order: then pulse yumi_i 4 times. Expect data_o data fields 0x1,0x2,0x3,0x4 in order, then v_o=0. fence_o stays 0 until 4 credit_v_i pulses, then fence_o=1 and out_credits_o=16.
- Credit exhaustion: with yumi_i tied to v_o and no credit_v_i, send 20 packets. Expect exactly 16 accepted and ready_o=0 with FIFO empty. One credit_v_i makes ready_o=1 next cycle, and one more packet is accepted.
- Simultaneous events: at count=2 and credits=10, hold v_i, yumi_i and credit_v_i high together for 1 cycle. Expect count=2, credits=10, and the head and tail each advance by 1 (including 3->0 wrap).
- Reset mid-operation: with count=3 and credits=5, assert reset_n_i low for 1 cycle. Expect v_o=0, count 0, credits 16. A subsequent spurious credit_v_i leaves credits at 16.
